// File: rtl/if_id_register.sv
// IF/ID pipeline register with a one-entry skid buffer.
// The main entry drives decode. The skid entry catches the fetch already in flight
// when decode stalls. A flush discards both entries. While main is empty, every
// output reads as zero, which decode sees as a NOP bubble.
module if_id_register #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_pc4,
    output logic              in_ready,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [DATA_W-1:0] out_pc4,
    output logic [5:0]        out_opcode,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [5:0]        out_funct,
    output logic [15:0]       out_imm
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;

    logic [DATA_W-1:0] r_main_instr;
    logic [DATA_W-1:0] r_main_pc4;
    logic [DATA_W-1:0] r_skid_instr;
    logic [DATA_W-1:0] r_skid_pc4;

    // State register; reset empties both entries immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and entry load controls. Flush overrides everything, including a
    // same-cycle input.
    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_next_state = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    // The input is taken even under stall, because nothing is held.
                    if (in_valid) begin
                        w_next_state   = FULL;
                        w_load_main_in = 1'b1;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        if (in_valid) begin
                            w_load_main_in = 1'b1;
                        end else begin
                            w_next_state = EMPTY;
                        end
                    end else if (in_valid) begin
                        w_next_state = SKID;
                        w_load_skid  = 1'b1;
                    end
                end
                SKID: begin
                    // in_ready is low here, so the only source for main is the skid entry.
                    if (!stall) begin
                        w_next_state     = FULL;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_next_state = EMPTY;
                end
            endcase
        end
    end

    // Main entry: loads from fetch, or from the skid entry when a stall is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_instr <= '0;
            r_main_pc4   <= '0;
        end else if (w_load_main_in) begin
            r_main_instr <= in_instr;
            r_main_pc4   <= in_pc4;
        end else if (w_load_main_skid) begin
            r_main_instr <= r_skid_instr;
            r_main_pc4   <= r_skid_pc4;
        end
    end

    // Skid entry: captures the fetch that arrives while decode is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_instr <= '0;
            r_skid_pc4   <= '0;
        end else if (w_load_skid) begin
            r_skid_instr <= in_instr;
            r_skid_pc4   <= in_pc4;
        end
    end

    // Outputs depend on registered state only. Stale data is masked to a zero bubble.
    always_comb begin
        in_ready   = (r_state != SKID);
        out_valid  = (r_state != EMPTY);
        out_instr  = out_valid ? r_main_instr : '0;
        out_pc4    = out_valid ? r_main_pc4   : '0;
        out_opcode = out_instr[31:26];
        out_rs     = out_instr[25:21];
        out_rt     = out_instr[20:16];
        out_rd     = out_instr[15:11];
        out_funct  = out_instr[5:0];
        out_imm    = out_instr[15:0];
    end

endmodule

// File: tb/tb_if_id_register.sv
// Testbench for if_id_register: directed scenarios, then a randomized run against
// a queue model of the two-entry buffer.
module tb_if_id_register;

    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_instr;
    logic [DATA_W-1:0] in_pc4;
    logic              in_ready;
    logic              stall;
    logic              flush;
    logic              out_valid;
    logic [DATA_W-1:0] out_instr;
    logic [DATA_W-1:0] out_pc4;
    logic [5:0]        out_opcode;
    logic [4:0]        out_rs;
    logic [4:0]        out_rt;
    logic [4:0]        out_rd;
    logic [5:0]        out_funct;
    logic [15:0]       out_imm;

    int vectors;
    int miscompares;

    if_id_register #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_pc4     (in_pc4),
        .in_ready   (in_ready),
        .stall      (stall),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc4    (out_pc4),
        .out_opcode (out_opcode),
        .out_rs     (out_rs),
        .out_rt     (out_rt),
        .out_rd     (out_rd),
        .out_funct  (out_funct),
        .out_imm    (out_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs, advance one rising edge, and settle just after it.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic st, input logic fl);
        in_valid = v;
        in_instr = ins;
        in_pc4   = pc;
        stall    = st;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_instr = '0; in_pc4 = '0; stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        vectors++;
        if (out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
        vectors++;
        if (out_pc4 !== 32'h0) begin miscompares++; $display("FAIL reset_out_pc4 got %h want 0", out_pc4); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_fields();
        cycle(1'b1, 32'h2008_FFFC, 32'h0000_0004, 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL fields_valid got %0b want 1", out_valid); end
        vectors++;
        if (out_imm !== 16'hFFFC) begin miscompares++; $display("FAIL fields_imm got %h want fffc", out_imm); end
        vectors++;
        if (out_rt !== 5'd8) begin miscompares++; $display("FAIL fields_rt got %0d want 8", out_rt); end
        vectors++;
        if (out_opcode !== 6'h08) begin miscompares++; $display("FAIL fields_opcode got %h want 08", out_opcode); end
        vectors++;
        if (out_rs !== 5'd0) begin miscompares++; $display("FAIL fields_rs got %0d want 0", out_rs); end
        vectors++;
        if (out_rd !== 5'd31) begin miscompares++; $display("FAIL fields_rd got %0d want 31", out_rd); end
        vectors++;
        if (out_funct !== 6'h3C) begin miscompares++; $display("FAIL fields_funct got %h want 3c", out_funct); end
        vectors++;
        if (out_pc4 !== 32'h4) begin miscompares++; $display("FAIL fields_pc4 got %h want 4", out_pc4); end
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0) begin
            miscompares++; $display("FAIL fields_drain valid=%0b instr=%h want 0/0", out_valid, out_instr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] seq [3];
        seq[0] = 32'h11; seq[1] = 32'h22; seq[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, seq[i], 32'h100 + 4 * i, 1'b0, 1'b0);
            vectors++;
            if (out_instr !== seq[i]) begin miscompares++; $display("FAIL stream_instr%0d got %h want %h", i, out_instr, seq[i]); end
            vectors++;
            if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready%0d got %0b want 1", i, in_ready); end
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_skid();
        cycle(1'b1, 32'hA, 32'h4, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 32'h8, 1'b1, 1'b0);
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL skid_ready got %0b want 0", in_ready); end
        vectors++;
        if (out_instr !== 32'hA) begin miscompares++; $display("FAIL skid_hold got %h want a", out_instr); end
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (out_instr !== 32'hB) begin miscompares++; $display("FAIL skid_release got %h want b", out_instr); end
        vectors++;
        if (out_pc4 !== 32'h8) begin miscompares++; $display("FAIL skid_pc4 got %h want 8", out_pc4); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL skid_ready_after got %0b want 1", in_ready); end
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        cycle(1'b1, 32'hA, 32'h4, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 32'h8, 1'b1, 1'b0);
        cycle(1'b1, 32'hC, 32'hC, 1'b1, 1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %0b want 0", out_valid); end
        vectors++;
        if (out_instr !== 32'h0) begin miscompares++; $display("FAIL flush_instr got %h want 0", out_instr); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %0b want 1", in_ready); end
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0) begin
            miscompares++; $display("FAIL flush_dropped valid=%0b instr=%h want 0/0", out_valid, out_instr);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 32'h55, 32'h10, 1'b0, 1'b0);
        cycle(1'b1, 32'h56, 32'h14, 1'b1, 1'b0);
        in_valid = 1'b0;
        stall    = 1'b0;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid got %0b want 0", out_valid); end
        vectors++;
        if (out_instr !== 32'h0) begin miscompares++; $display("FAIL arst_instr got %h want 0", out_instr); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL arst_ready got %0b want 1", in_ready); end
        #1 rst = 1'b0;
        cycle(1'b1, 32'h66, 32'h18, 1'b0, 1'b0);
        vectors++;
        if (out_instr !== 32'h66 || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL arst_first got %h/%0b want 66/1", out_instr, out_valid);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_no_dup got %0b want 0", out_valid); end
    endtask

    task automatic test_random();
        logic [31:0] q_instr [$];
        logic [31:0] q_pc4   [$];
        logic [31:0] tmp;
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        v, st, fl, rdy;
        int          errs;
        errs = 0;
        for (int i = 0; i < 10000; i++) begin
            tmp = $urandom;
            ins = {tmp[31:16], i[15:0]};
            pc  = $urandom;
            v   = ($urandom_range(99) < 70);
            st  = ($urandom_range(99) < 40);
            fl  = ($urandom_range(99) < 5);
            cycle(v, ins, pc, st, fl);
            // Reference: at most two instructions in flight; the head is what decode sees.
            if (fl) begin
                q_instr.delete();
                q_pc4.delete();
            end else begin
                rdy = (q_instr.size() < 2);
                if (q_instr.size() > 0 && !st) begin
                    void'(q_instr.pop_front());
                    void'(q_pc4.pop_front());
                end
                if (v && rdy) begin
                    q_instr.push_back(ins);
                    q_pc4.push_back(pc);
                end
            end
            e_instr = (q_instr.size() > 0) ? q_instr[0] : 32'h0;
            e_pc4   = (q_pc4.size() > 0) ? q_pc4[0] : 32'h0;
            vectors++;
            if (out_valid !== (q_instr.size() > 0) || out_instr !== e_instr || out_pc4 !== e_pc4 ||
                in_ready !== (q_instr.size() < 2) || out_opcode !== e_instr[31:26] ||
                out_rs !== e_instr[25:21] || out_rt !== e_instr[20:16] || out_rd !== e_instr[15:11] ||
                out_funct !== e_instr[5:0] || out_imm !== e_instr[15:0]) begin
                miscompares++;
                errs++;
                if (errs <= 10) begin
                    $display("FAIL random_cycle%0d got v=%0b instr=%h pc4=%h rdy=%0b want v=%0b instr=%h pc4=%h rdy=%0b",
                             i, out_valid, out_instr, out_pc4, in_ready,
                             (q_instr.size() > 0), e_instr, e_pc4, (q_instr.size() < 2));
                end
            end
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_fields();
        test_stream();
        test_skid();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
